noc_merge_arb: RTL and testbench
================================

NOC_MERGE_ARB -- requirements
Module: noc_merge_arb

Interface
REQ-001 SHALL have parameter W, default 9, flit width: bit W-1 = tail flag, bits W-2:0 = payload.
REQ-002 SHALL have parameter SEL_BIT, default 0, header-flit payload bit carrying the decoder route select.
REQ-003 SHALL have port CLK  input  1  the single clock; all state is updated on rising edge.
REQ-004 SHALL have port _RESET  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port In0_data  input  W  requester-0 flit.
REQ-006 SHALL have port In0_valid  input  1  requester-0 flit offered.
REQ-007 SHALL have port In0_ready  output  1  requester-0 flit accepted.
REQ-008 SHALL have ports In1_data, In1_valid and In1_ready, identical to the In0 ports for requester 1.
REQ-009 SHALL have port Out_data  output  W  flit forwarded to the shared decoder input.
REQ-010 SHALL have port Out_valid  output  1  Out_data held.
REQ-011 SHALL have port Out_ready  input  1  decoder input accepts.
REQ-012 SHALL have port S_data  output  1  route select token for the decoder.
REQ-013 SHALL have port S_valid  output  1  S_data held.
REQ-014 SHALL have port S_ready  input  1  decoder accepts the select.

Function
REQ-015 SHALL treat a transfer on any channel as valid&&ready high at a rising CLK edge.
REQ-016 SHALL run the FSM IDLE -> LOCK0 | LOCK1 -> IDLE, where the LOCKn states hold the grant for one whole packet.
REQ-017 In IDLE, SHALL grant the single valid requester, or the requester other than last_grant when both are valid; last_grant SHALL reset to 1 so that In0 wins the first tie.
REQ-018 SHALL accept a head flit only when the Out register is empty or draining in the same cycle, and the S register is empty or draining in the same cycle.
REQ-019 On head-flit acceptance, SHALL load S_data from payload bit SEL_BIT, set S_valid, and update last_grant.
REQ-020 SHALL accept a head flit with the tail flag set as a 1-flit packet, and SHALL then remain in IDLE.
REQ-021 In LOCKn, SHALL assert Inn_ready only when the Out register can accept, and SHALL hold the other requester's ready at 0.
REQ-022 SHALL return to IDLE on the transfer of the tail flit.
REQ-023 SHALL provide a 1-entry Out register with latency of 1 cycle from In transfer to Out_valid, and full throughput of 1 flit per cycle when Out_ready is held high.
REQ-024 SHALL keep Out_data and S_data stable while their valid is high and ready is low.
REQ-025 SHALL issue exactly one S token per packet, and SHALL never issue an S token for a body or tail flit.
REQ-026 SHALL ignore requester valid drops mid-packet: the lock is held and no flits from the other requester are interleaved.

Reset
REQ-027 While _RESET is low, SHALL force state=IDLE, last_grant=1, Out_valid=0, S_valid=0, In0_ready=0, In1_ready=0, Out_data=0, S_data=0, and all counters to 0.
REQ-028 SHALL discard any partial packet on reset assertion mid-packet, with no tail flit emitted.

Configuration
REQ-029 With macro NOC_MERGE_ARB_STATS_EN defined, SHALL add outputs pkt_cnt0[15:0] and pkt_cnt1[15:0], each counting granted head flits per requester and saturating at 16'hFFFF.
REQ-030 With NOC_MERGE_ARB_STATS_EN undefined, SHALL omit those ports and counters, with all other behaviour identical.

Structure
REQ-031 SHALL place the FSM state enum (IDLE, LOCK0, LOCK1) and the flit tail-bit index constant in shared package noc_arb_pkg.
REQ-032 SHALL implement the Out and S holding registers with one sub-module, hold_reg (valid/ready 1-entry register with pass-through on drain), instantiated twice.

Verification
REQ-033 Check: In0 3-flit packet {0x001, 0x0AA, 0x1FF}, Out_ready=1 -> Out carries the same 3 flits on consecutive cycles starting 1 cycle later; one S token =1.
REQ-034 Check: In0 and In1 both valid from reset with 2-flit packets -> In0 packet forwarded first, then In1; In0 and In1 flits are never interleaved.
REQ-035 Check: after In0 and In1 have contended, both keep packets pending -> grants alternate 0,1,0,1 over 4 packets.
REQ-036 Check: S_ready=0 with In1 1-flit packet 0x100 -> S_valid=1 and S_data=0 held; next head flit stalls until S_ready=1.
REQ-037 Check: _RESET pulsed low mid-packet on In0 -> all valids drop immediately; after release, IDLE and In1 is served first only if it alone is valid.
REQ-038 Check: with NOC_MERGE_ARB_STATS_EN, force pkt_cnt0 to 16'hFFFE and send 3 packets on In0 -> pkt_cnt0=16'hFFFF, with no wrap.

Source files
------------

// File: rtl/noc_arb_pkg.sv
// Shared types and constants for the NoC merge arbiter: FSM state encoding and flit layout.
package noc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  localparam int unsigned NOC_FLIT_W = 9;

  // Tail flag always sits in the flit MSB, whatever the configured width.
  function automatic int unsigned flit_tail_bit(input int unsigned w);
    return w - 1;
  endfunction

  localparam int unsigned NOC_TAIL_BIT = flit_tail_bit(NOC_FLIT_W);

endpackage

// File: rtl/noc_merge_arb_hold_reg.sv
// hold_reg: one-entry valid/ready holding register; accepts a new word in the same cycle it drains.
module hold_reg #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/noc_merge_arb.sv
// noc_merge_arb: 2:1 round-robin merge that locks onto one requester for a whole packet and
// issues one route-select token per packet. NOC_MERGE_ARB_STATS_EN adds saturating packet counters.
module noc_merge_arb
  import noc_arb_pkg::*;
#(
  parameter int unsigned W       = NOC_FLIT_W,
  parameter int unsigned SEL_BIT = 0
) (
  input  logic         CLK,
  input  logic         _RESET,
  input  logic [W-1:0] In0_data,
  input  logic         In0_valid,
  output logic         In0_ready,
  input  logic [W-1:0] In1_data,
  input  logic         In1_valid,
  output logic         In1_ready,
  output logic [W-1:0] Out_data,
  output logic         Out_valid,
  input  logic         Out_ready,
  output logic         S_data,
  output logic         S_valid,
  input  logic         S_ready
`ifdef NOC_MERGE_ARB_STATS_EN
  ,
  output logic [15:0]  pkt_cnt0,
  output logic [15:0]  pkt_cnt1
`endif
);

  localparam int unsigned TAIL = flit_tail_bit(W);

  arb_state_e   state;
  logic         last_grant;
  logic         out_can;
  logic         s_can;
  logic         pick;
  logic         rdy0;
  logic         rdy1;
  logic         xfer0;
  logic         xfer1;
  logic         any_xfer;
  logic         head_xfer;
  logic [W-1:0] flit;

  // pick=1 selects In1; on a tie the requester that did not win last time goes next.
  always_comb begin
    pick = (In0_valid && In1_valid) ? ~last_grant : (In1_valid && !In0_valid);
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    case (state)
      IDLE: begin
        rdy0 = In0_valid && !pick && out_can && s_can;
        rdy1 = In1_valid &&  pick && out_can && s_can;
      end
      LOCK0:   rdy0 = out_can;
      LOCK1:   rdy1 = out_can;
      default: ;
    endcase
  end

  // Readies are masked by reset so nothing is taken while the holding registers are cleared.
  assign In0_ready = rdy0 && _RESET;
  assign In1_ready = rdy1 && _RESET;
  assign xfer0     = In0_valid && In0_ready;
  assign xfer1     = In1_valid && In1_ready;
  assign any_xfer  = xfer0 || xfer1;
  assign head_xfer = (state == IDLE) && any_xfer;
  assign flit      = xfer1 ? In1_data : In0_data;

  hold_reg #(.W(W)) u_out_reg (
    .clk       (CLK),
    .rst_n     (_RESET),
    .in_data   (flit),
    .in_valid  (any_xfer),
    .in_ready  (out_can),
    .out_data  (Out_data),
    .out_valid (Out_valid),
    .out_ready (Out_ready)
  );

  hold_reg #(.W(1)) u_sel_reg (
    .clk       (CLK),
    .rst_n     (_RESET),
    .in_data   (flit[SEL_BIT]),
    .in_valid  (head_xfer),
    .in_ready  (s_can),
    .out_data  (S_data),
    .out_valid (S_valid),
    .out_ready (S_ready)
  );

  // A single-flit packet (head with tail set) never leaves IDLE.
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (head_xfer) begin
            last_grant <= xfer1;
            if (!flit[TAIL]) state <= xfer1 ? LOCK1 : LOCK0;
          end
        end
        LOCK0:   if (xfer0 && In0_data[TAIL]) state <= IDLE;
        LOCK1:   if (xfer1 && In1_data[TAIL]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NOC_MERGE_ARB_STATS_EN
  logic [15:0] cnt0;
  logic [15:0] cnt1;

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (head_xfer) begin
      if (xfer0 && cnt0 != 16'hFFFF) cnt0 <= cnt0 + 16'd1;
      if (xfer1 && cnt1 != 16'hFFFF) cnt1 <= cnt1 + 16'd1;
    end
  end

  assign pkt_cnt0 = cnt0;
  assign pkt_cnt1 = cnt1;
`endif

endmodule

// File: tb/tb_noc_merge_arb.sv
// Scoreboard bench for noc_merge_arb: randomized packet streams checked against a packet-level
// round-robin model. Define NOC_MERGE_ARB_STATS_EN to also exercise the packet counters.
`timescale 1ns/1ps
module tb_noc_merge_arb;

  localparam int W       = 9;
  localparam int SEL_BIT = 0;

  logic         CLK       = 1'b0;
  logic         _RESET;
  logic [W-1:0] In0_data  = '0;
  logic         In0_valid = 1'b0;
  logic         In0_ready;
  logic [W-1:0] In1_data  = '0;
  logic         In1_valid = 1'b0;
  logic         In1_ready;
  logic [W-1:0] Out_data;
  logic         Out_valid;
  logic         Out_ready = 1'b0;
  logic         S_data;
  logic         S_valid;
  logic         S_ready   = 1'b0;
`ifdef NOC_MERGE_ARB_STATS_EN
  logic [15:0]  pkt_cnt0;
  logic [15:0]  pkt_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  // Stimulus flit streams per requester, and scoreboard queues for Out and S.
  logic [W-1:0] pq0[$];
  logic [W-1:0] pq1[$];
  logic [W-1:0] out_exp[$];
  bit           s_exp[$];
  bit           grant_log[$];

  // Packet-level model state.
  bit busy;
  bit owner;
  bit last_g = 1'b1;
  int heads0, heads1;

  // Handshake results seen at the last edge, and per-requester "inside a packet" flags.
  bit x0, x1;
  bit mid0, mid1;

  int vprob = 100;
  int oprob = 100;
  int sprob = 100;

  always #5 CLK = ~CLK;

  noc_merge_arb #(.W(W), .SEL_BIT(SEL_BIT)) dut (
    .CLK       (CLK),
    ._RESET    (_RESET),
    .In0_data  (In0_data),
    .In0_valid (In0_valid),
    .In0_ready (In0_ready),
    .In1_data  (In1_data),
    .In1_valid (In1_valid),
    .In1_ready (In1_ready),
    .Out_data  (Out_data),
    .Out_valid (Out_valid),
    .Out_ready (Out_ready),
    .S_data    (S_data),
    .S_valid   (S_valid),
    .S_ready   (S_ready)
`ifdef NOC_MERGE_ARB_STATS_EN
    ,
    .pkt_cnt0  (pkt_cnt0),
    .pkt_cnt1  (pkt_cnt1)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int vp, input int op, input int sp);
    vprob = vp;
    oprob = op;
    sprob = sp;
  endtask

  task automatic addFlit(input bit req, input logic [W-1:0] f);
    if (req) pq1.push_back(f);
    else     pq0.push_back(f);
  endtask

  task automatic addRandomPacket(input bit req);
    int len;
    logic [W-1:0] f;
    len = $urandom_range(4, 1);
    for (int i = 0; i < len; i++) begin
      f = W'($urandom);
      f[W-1] = (i == len - 1);
      addFlit(req, f);
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((pq0.size() != 0 || pq1.size() != 0 || out_exp.size() != 0 || s_exp.size() != 0)
           && n < budget) begin
      @(posedge CLK);
      n++;
    end
    checkOutput(tag, (n >= budget), 0);
  endtask

  // Called at posedge+3; checks the reset values the DUT must show immediately.
  task automatic doReset();
    _RESET = 1'b0;
    #1;
    checkOutput("rst_out_valid", Out_valid, 0);
    checkOutput("rst_s_valid", S_valid, 0);
    checkOutput("rst_in0_ready", In0_ready, 0);
    checkOutput("rst_in1_ready", In1_ready, 0);
    checkOutput("rst_out_data", Out_data, 0);
    checkOutput("rst_s_data", S_data, 0);
`ifdef NOC_MERGE_ARB_STATS_EN
    checkOutput("rst_pkt_cnt0", pkt_cnt0, 0);
`endif
    repeat (2) @(posedge CLK);
    #3 _RESET = 1'b1;
  endtask

  // Driver: after each edge, retire accepted flits and re-randomize valids and downstream readies.
  always @(posedge CLK) begin : driver
    logic [W-1:0] f;
    #1;
    if (!_RESET) begin
      if (mid0) while (pq0.size() != 0) begin f = pq0.pop_front(); if (f[W-1]) break; end
      if (mid1) while (pq1.size() != 0) begin f = pq1.pop_front(); if (f[W-1]) break; end
      mid0 = 1'b0;
      mid1 = 1'b0;
    end else begin
      if (x0 && pq0.size() != 0) begin f = pq0.pop_front(); mid0 = !f[W-1]; end
      if (x1 && pq1.size() != 0) begin f = pq1.pop_front(); mid1 = !f[W-1]; end
    end
    In0_valid = (pq0.size() != 0) && ($urandom_range(99) < vprob);
    In0_data  = (pq0.size() != 0) ? pq0[0] : '0;
    In1_valid = (pq1.size() != 0) && ($urandom_range(99) < vprob);
    In1_data  = (pq1.size() != 0) ? pq1[0] : '0;
    Out_ready = ($urandom_range(99) < oprob);
    S_ready   = ($urandom_range(99) < sprob);
  end

  // Monitor/model: just before each edge, predict readies and valids from packet-level rules,
  // pop and compare drained Out/S words, then record what the DUT accepts this edge.
  always @(negedge CLK) begin : monitor
    bit can_out, can_s, g, e0, e1, rr0, rr1;
    logic [W-1:0] f;
    if (!_RESET) begin
      out_exp.delete();
      s_exp.delete();
      busy   = 1'b0;
      last_g = 1'b1;
      heads0 = 0;
      heads1 = 0;
      x0     = 1'b0;
      x1     = 1'b0;
    end else begin
      checkOutput("out_valid", Out_valid, out_exp.size() != 0);
      checkOutput("s_valid", S_valid, s_exp.size() != 0);
      can_out = (out_exp.size() == 0) || Out_ready;
      can_s   = (s_exp.size() == 0) || S_ready;
      e0 = 1'b0;
      e1 = 1'b0;
      if (!busy) begin
        g = (In0_valid && In1_valid) ? !last_g : !In0_valid;
        if (can_out && can_s) begin
          e0 = In0_valid && !g;
          e1 = In1_valid && g;
        end
      end else if (owner) e1 = can_out;
      else                e0 = can_out;
      checkOutput("in0_ready", In0_ready, e0);
      checkOutput("in1_ready", In1_ready, e1);
      if (Out_valid && Out_ready && out_exp.size() != 0)
        checkOutput("out_data", Out_data, out_exp.pop_front());
      if (S_valid && S_ready && s_exp.size() != 0)
        checkOutput("s_data", S_data, s_exp.pop_front());
      rr0 = In0_valid && In0_ready;
      rr1 = In1_valid && In1_ready;
      checkOutput("single_grant", rr0 && rr1, 0);
      if (rr0 || rr1) begin
        f = rr1 ? In1_data : In0_data;
        out_exp.push_back(f);
        if (!busy) begin
          last_g = rr1;
          s_exp.push_back(f[SEL_BIT]);
          grant_log.push_back(rr1);
          if (rr1) begin if (heads1 < 65535) heads1++; end
          else     begin if (heads0 < 65535) heads0++; end
          if (!f[W-1]) begin busy = 1'b1; owner = rr1; end
        end else if (f[W-1]) busy = 1'b0;
      end
      x0 = rr0;
      x1 = rr1;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by a randomized run.
  initial begin : stimulus
    int n;
    _RESET = 1'b0;
    applyStimulus(100, 100, 100);

    // Three-flit packet on In0 with a free downstream.
    addFlit(0, 9'h001);
    addFlit(0, 9'h0AA);
    addFlit(0, 9'h1FF);
    doReset();
    drain("drain_basic", 200);

    // Both requesters valid straight out of reset with 2-flit packets: In0 must go first.
    @(posedge CLK); #3;
    addFlit(0, 9'h012); addFlit(0, 9'h134);
    addFlit(1, 9'h057); addFlit(1, 9'h179);
    grant_log.delete();
    doReset();
    drain("drain_tie", 200);
    checkOutput("tie_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      checkOutput("tie_first", grant_log[0], 0);
      checkOutput("tie_second", grant_log[1], 1);
    end

    // Sustained contention: grants must alternate.
    grant_log.delete();
    for (int i = 0; i < 2; i++) begin
      addFlit(0, 9'h021); addFlit(0, 9'h1A0);
      addFlit(1, 9'h0C3); addFlit(1, 9'h13C);
    end
    drain("drain_rr", 300);
    checkOutput("rr_grants", grant_log.size(), 4);
    if (grant_log.size() == 4)
      for (int i = 0; i < 4; i++) checkOutput("rr_order", grant_log[i], i % 2);

    // Select path blocked: the token is held and the next head stalls.
    applyStimulus(100, 100, 0);
    addFlit(1, 9'h100);
    n = 0;
    while ((pq1.size() != 0 || out_exp.size() != 0) && n < 50) begin @(posedge CLK); n++; end
    checkOutput("s_block_timeout", (n >= 50), 0);
    addFlit(0, 9'h003); addFlit(0, 9'h1F0);
    repeat (5) @(posedge CLK);
    #3;
    checkOutput("s_held_valid", S_valid, 1);
    checkOutput("s_held_data", S_data, 0);
    checkOutput("head_stalled", pq0.size(), 2);
    applyStimulus(100, 100, 100);
    drain("drain_sblock", 200);

    // Reset in the middle of a long In0 packet; afterwards only In1 offers a packet.
    for (int i = 0; i < 5; i++) addFlit(0, (i == 4) ? 9'h1E5 : W'(9'h040 + i));
    n = 0;
    while (!mid0 && n < 50) begin @(posedge CLK); n++; end
    checkOutput("mid_timeout", (n >= 50), 0);
    @(posedge CLK); #3;
    grant_log.delete();
    addFlit(1, 9'h0F1); addFlit(1, 9'h1F2);
    doReset();
    drain("drain_after_rst", 200);
    checkOutput("post_rst_grants", grant_log.size(), 1);
    if (grant_log.size() != 0) checkOutput("post_rst_first", grant_log[0], 1);
    checkOutput("partial_dropped", pq0.size(), 0);

`ifdef NOC_MERGE_ARB_STATS_EN
    @(posedge CLK); #3;
    force dut.cnt0 = 16'hFFFE;
    heads0 = 65534;
    @(posedge CLK); #3;
    release dut.cnt0;
    for (int i = 0; i < 3; i++) addRandomPacket(0);
    drain("drain_stats", 300);
    checkOutput("pkt_cnt0_sat", pkt_cnt0, 16'hFFFF);
    checkOutput("pkt_cnt1", pkt_cnt1, heads1);
`endif

    // Randomized traffic with valid drops and downstream back-pressure.
    applyStimulus(70, 60, 60);
    for (int i = 0; i < 30; i++) begin
      addRandomPacket(0);
      addRandomPacket(1);
    end
    drain("drain_random", 8000);
`ifdef NOC_MERGE_ARB_STATS_EN
    checkOutput("pkt_cnt1_final", pkt_cnt1, heads1);
`endif

    repeat (3) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
